// File: rtl/aura_pkg.sv
// Shared definitions for the reduction arbiter slice.
// Provides default sizing (vector length, element width, result width, tag
// depth), the requester tag and result types, and a tag-width helper that
// keeps a one-bit tag legal for degenerate requester counts.
`ifndef MAX_EMBEDDING_DIM
`define MAX_EMBEDDING_DIM 4
`endif
`ifndef INTEGER_WIDTH
`define INTEGER_WIDTH 8
`endif

package aura_pkg;

  localparam int NUM_REQ_DEF   = 2;
  localparam int INPUT_LEN_DEF = `MAX_EMBEDDING_DIM;
  localparam int W_IN_DEF      = 2 * `INTEGER_WIDTH;
  localparam int W_OUT_DEF     = W_IN_DEF + $clog2(INPUT_LEN_DEF);
  localparam int TAG_DEPTH_DEF = 4;

  localparam int REQ_TAG_W = $clog2(NUM_REQ_DEF);

  typedef logic [REQ_TAG_W-1:0]        req_tag_t;
  typedef logic signed [W_OUT_DEF-1:0] sum_t;

  // Width of a tag addressing n requesters, never narrower than one bit.
  function automatic int tag_w(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/tag_fifo.sv
// In-order tag FIFO.
// Records which requester issued each in-flight tree transaction so the
// result can be steered back in issue order. Push and pop may coincide;
// push while full and pop while empty are ignored.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   push/push_data write one tag
//   pop            retire the head tag
//   head           tag at the read pointer
//   full, empty    occupancy flags
//   count          current occupancy (0..DEPTH)
module tag_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Pointers wrap explicitly so non-power-of-two depths also work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) begin
      return {AW{1'b0}};
    end else begin
      return p + AW'(1);
    end
  endfunction

  // Qualify push/pop against the registered occupancy.
  always_comb begin
    push_ok_s = push && (count_r != CW'(DEPTH));
    pop_ok_s  = pop && (count_r != {CW{1'b0}});
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == {CW{1'b0}});
  assign count = count_r;

endmodule

// File: rtl/reduction_arbiter.sv
// Round-robin front end sharing one pairwise-sum reduction tree between
// NUM_REQ requester lanes.
// Issue path: picks the first valid requester at or after the round-robin
// pointer, forwards its vector to the tree and records its tag.
// Return path: steers each tree result to the requester at the head of the
// tag FIFO; the result bus is shared and qualified per requester.
// Ports:
//   req_vld_in/req_rdy_out/req_list_in    requester vectors in
//   tree_vld_out/tree_rdy_in/tree_list_out vector toward the tree
//   tree_vld_in/tree_rdy_out/tree_sum_in  result from the tree
//   res_vld_out/res_rdy_in/res_sum_out    results back to requesters
//   inflight_out                          tag FIFO occupancy
//   err_out                               sticky orphan-result error
module reduction_arbiter
  import aura_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int INPUT_LEN = INPUT_LEN_DEF,
  parameter int W_IN      = W_IN_DEF,
  parameter int W_OUT     = W_IN + $clog2(INPUT_LEN),
  parameter int TAG_DEPTH = TAG_DEPTH_DEF
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [NUM_REQ-1:0]                             req_vld_in,
  output logic [NUM_REQ-1:0]                             req_rdy_out,
  input  logic signed [NUM_REQ-1:0][INPUT_LEN-1:0][W_IN-1:0] req_list_in,
  output logic                                           tree_vld_out,
  input  logic                                           tree_rdy_in,
  output logic signed [INPUT_LEN-1:0][W_IN-1:0]          tree_list_out,
  input  logic                                           tree_vld_in,
  output logic                                           tree_rdy_out,
  input  logic signed [W_OUT-1:0]                        tree_sum_in,
  output logic [NUM_REQ-1:0]                             res_vld_out,
  input  logic [NUM_REQ-1:0]                             res_rdy_in,
  output logic signed [W_OUT-1:0]                        res_sum_out,
  output logic [$clog2(TAG_DEPTH+1)-1:0]                 inflight_out,
  output logic                                           err_out
);

  localparam int TAG_W = tag_w(NUM_REQ);

  logic [TAG_W-1:0] ptr_r;
  logic [TAG_W-1:0] grant_s;
  logic             found_s;
  logic             issue_ok_s;
  logic             fire_s;
  logic             pop_s;
  logic [TAG_W-1:0] head_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic             err_r;

  // Round-robin successor of a granted index.
  function automatic logic [TAG_W-1:0] next_ptr(input logic [TAG_W-1:0] g);
    if (g == TAG_W'(NUM_REQ - 1)) begin
      return {TAG_W{1'b0}};
    end else begin
      return g + TAG_W'(1);
    end
  endfunction

  // Grant search: first valid requester from the pointer upward, wrapping.
  always_comb begin
    logic [TAG_W:0]   wrap_s;
    logic [TAG_W-1:0] idx_s;
    wrap_s  = {(TAG_W+1){1'b0}};
    idx_s   = {TAG_W{1'b0}};
    grant_s = ptr_r;
    found_s = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      wrap_s = {1'b0, ptr_r} + (TAG_W+1)'(k);
      if (wrap_s >= (TAG_W+1)'(NUM_REQ)) begin
        idx_s = TAG_W'(wrap_s - (TAG_W+1)'(NUM_REQ));
      end else begin
        idx_s = wrap_s[TAG_W-1:0];
      end
      if (!found_s && req_vld_in[idx_s]) begin
        found_s = 1'b1;
        grant_s = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Issue path. Gating on the registered occupancy keeps the result path
  // out of the ready chain: a same-cycle pop never frees a slot.
  always_comb begin
    issue_ok_s    = !fifo_full_s;
    tree_vld_out  = issue_ok_s && found_s;
    tree_list_out = req_list_in[grant_s];
    req_rdy_out   = {NUM_REQ{1'b0}};
    if (tree_vld_out) begin
      req_rdy_out[grant_s] = tree_rdy_in;
    end else begin
      req_rdy_out = {NUM_REQ{1'b0}};
    end
    fire_s = tree_vld_out && tree_rdy_in;
  end

  // Return path: results go to the requester whose tag is at the head.
  always_comb begin
    res_vld_out  = {NUM_REQ{1'b0}};
    tree_rdy_out = 1'b0;
    res_sum_out  = tree_sum_in;
    if (!fifo_empty_s) begin
      res_vld_out[head_s] = tree_vld_in;
      tree_rdy_out        = res_rdy_in[head_s];
    end else begin
      res_vld_out  = {NUM_REQ{1'b0}};
      tree_rdy_out = 1'b0;
    end
    pop_s = tree_vld_in && tree_rdy_out;
  end

  // Round-robin pointer; a stalled valid requester keeps its priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= {TAG_W{1'b0}};
    end else if (fire_s) begin
      ptr_r <= next_ptr(grant_s);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Sticky error on a tree result with no outstanding tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (tree_vld_in && fifo_empty_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err_out = err_r;

  tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fire_s),
    .push_data (grant_s),
    .pop       (pop_s),
    .head      (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (inflight_out)
  );

endmodule

// File: doc/reduction_arbiter.md
Name: reduction_arbiter

Overview:
- Shares one reduction_step pipeline (the pairwise-sum tree) between NUM_REQ requesters, e.g. several Q·K score lanes.
- Picks one requester vector per cycle by round-robin, forwards it into the tree, and records its tag in an in-order tag FIFO.
- Steers each tree result back to the requester that issued it.
- Sits between the requester lanes and the tree; the tree itself is not modified.

Parameters:
- NUM_REQ, 2, number of requesters (≥2).
- INPUT_LEN, `MAX_EMBEDDING_DIM, elements per vector.
- W_IN, 2*`INTEGER_WIDTH, element width.
- W_OUT, W_IN+$clog2(INPUT_LEN), result width returned by the tree.
- TAG_DEPTH, 4, maximum transactions in flight. Must be ≥ the total number of tree register stages.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- req_vld_in, input, NUM_REQ, per-requester vector valid.
- req_rdy_out, output, NUM_REQ, per-requester accept.
- req_list_in, input, NUM_REQ x INPUT_LEN x W_IN signed, per-requester vectors.
- tree_vld_out, output, 1, vector valid toward the tree.
- tree_rdy_in, input, 1, tree input ready.
- tree_list_out, output, INPUT_LEN x W_IN signed, muxed vector toward the tree.
- tree_vld_in, input, 1, tree result valid.
- tree_rdy_out, output, 1, ready toward the tree output.
- tree_sum_in, input, W_OUT signed, tree result.
- res_vld_out, output, NUM_REQ, per-requester result valid.
- res_rdy_in, input, NUM_REQ, per-requester result ready.
- res_sum_out, output, W_OUT signed, result data, shared by all requesters and qualified by res_vld_out.
- inflight_out, output, $clog2(TAG_DEPTH+1), current tag FIFO occupancy.
- err_out, output, 1, sticky protocol error.

Behaviour:
- Clocking and reset:
  - Single clock clk; rst is synchronous and active-high.
  - Reset clears: round-robin pointer to 0, tag FIFO to empty, inflight_out to 0, err_out to 0.
  - After reset, all res_vld_out are 0. tree_vld_out is 0 unless a req_vld_in is high.
- Issue path (combinational, zero added latency):
  - Issue is allowed only when inflight < TAG_DEPTH. A pop in the same cycle does not free a slot, so there is no rdy loop through the result path.
  - While allowed: grant = first i with req_vld_in[i], searching from the pointer upward with wrap modulo NUM_REQ.
  - tree_vld_out = any granted; tree_list_out = req_list_in[grant].
  - req_rdy_out[grant] = tree_rdy_in; all other req_rdy_out are 0.
  - When no requester is valid, tree_list_out holds the vector of req_list_in[pointer].
  - Issue fires when tree_vld_out && tree_rdy_in. On fire: push grant into the tag FIFO and set pointer = (grant+1) mod NUM_REQ.
  - Without a fire, the pointer holds. A requester that is valid but stalled keeps its priority.
- Return path (combinational):
  - head = tag at the FIFO read pointer.
  - FIFO non-empty: res_vld_out[head] = tree_vld_in; tree_rdy_out = res_rdy_in[head]; res_sum_out = tree_sum_in.
  - FIFO empty: tree_rdy_out = 0 and res_vld_out = 0.
  - Pop fires when tree_vld_in && tree_rdy_out.
- Tag FIFO:
  - TAG_DEPTH entries of $clog2(NUM_REQ) bits; read and write pointers wrap modulo TAG_DEPTH.
  - Push and pop may occur in the same cycle: occupancy is unchanged and both pointers advance.
  - Push while full cannot occur, because issue is gated. Pop while empty cannot occur, because tree_rdy_out is 0.
- Error:
  - err_out sets if tree_vld_in=1 while the FIFO is empty (a result with no matching tag).
  - Once set, err_out stays set until rst. Data flow is otherwise unaffected.
- Ordering:
  - The tree is in-order, so results return in issue order.
  - A requester that never asserts res_rdy_in stalls the return path for everyone. This head-of-line blocking is intended.
- Reset mid-operation: the FIFO is cleared and in-flight tags are discarded. The tree must be reset on the same rst so no orphan results appear.

Decomposition:
- Shared package aura_pkg:
  - REQ_TAG_W = $clog2(NUM_REQ) and the req_tag_t typedef.
  - sum_t typedef for W_OUT-wide signed results.
- One sub-module: tag_fifo. Synchronous FIFO with push/pop, full/empty and count outputs, parameterised on width and depth.
- The round-robin grant logic stays inline in reduction_arbiter.

Test Plan:
- Single requester: NUM_REQ=2, only req 0 streams 4 vectors of all-ones (value 1), tree_rdy_in=1 throughout.
  - Required: 4 results on res 0 of value INPUT_LEN each; res_vld_out[1] never asserts; inflight_out peaks ≤ tree depth.
- Fairness: both requesters valid continuously for 8 issues.
  - Required: grants alternate 0,1,0,1,…; each requester receives 4 results, in order.
- Backpressure: res_rdy_in[0]=0 for 10 cycles with both requesters active.
  - Required: inflight_out saturates at TAG_DEPTH; all req_rdy_out drop to 0; no result is lost or duplicated after res_rdy_in[0] returns to 1.
- Simultaneous push/pop at full: hold inflight=TAG_DEPTH, then fire a pop.
  - Required: no issue in the pop cycle; an issue occurs in the next cycle; inflight returns to TAG_DEPTH.
- Protocol error: drive tree_vld_in=1 with the FIFO empty.
  - Required: err_out=1 from the next cycle; it stays 1 until rst; rst clears it and inflight_out reads 0.
- Reset mid-stream: assert rst with 3 transactions in flight.
  - Required: the next cycle shows inflight_out=0, pointer back to 0 (req 0 wins a tie), and err_out=0.
